// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: FSM encoding,
// word-alignment mask and the default watchdog limit.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } memState_e;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_access_ctrl_watchdog.sv
// Eight-bit saturating clear/increment counter that flags when a transaction
// has been outstanding for TIMEOUT_CYCLES cycles.
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] Limit = 8'(TIMEOUT_CYCLES);

    logic [7:0] countQ;
    logic [7:0] countD;

    always_comb begin
        countD = countQ;
        if (clr_i) begin
            countD = 8'd0;
        end else if (inc_i && (countQ != 8'hFF)) begin
            countD = countQ + 8'd1;
        end
    end

    // Look at the post-increment value so the abort lands on the Nth busy cycle.
    assign expired_o = inc_i && !clr_i && (countD >= Limit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            countQ <= 8'd0;
        end else begin
            countQ <= countD;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns a one-cycle load/store into a req/ack memory
// transaction, stalls the pipeline while it is outstanding and returns load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] MemData_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    memState_e stateQ;
    memState_e stateD;

    logic access;
    logic aligned;
    logic accept;
    logic busy;
    logic ackHit;
    logic wdExpired;
    logic timeout;

    assign access  = MemRead_i | MemWrite_i;
    assign aligned = (Addr_i[1:0] == 2'b00);
    assign accept  = (stateQ == StIdle) && access && aligned;
    assign busy    = (stateQ == StBusy);
    assign ackHit  = busy && mem_ack_i;
    // An ack arriving on the expiry cycle still completes the transaction normally.
    assign timeout = busy && !mem_ack_i && wdExpired;

    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept),
        .inc_i    (busy),
        .expired_o(wdExpired)
    );

    always_comb begin
        stateD     = stateQ;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (access && aligned) begin
                    stall_o = 1'b1;
                    stateD  = StBusy;
                end else if (access) begin
                    misalign_o = 1'b1;
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                if (ackHit || timeout) begin
                    stateD = StDone;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
        if (rst_i) begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            MemData_o   <= 32'd0;
            bus_err_o   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            bus_err_o <= 1'b0;
            if (accept) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= MemWrite_i;
                mem_addr_o  <= Addr_i & WORD_ALIGN_MASK;
                mem_wdata_o <= WriteData_i;
            end else if (ackHit) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) begin
                    MemData_o <= mem_rdata_i;
                end
            end else if (timeout) begin
                mem_req_o <= 1'b0;
                MemData_o <= 32'd0;
                bus_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected load data goes into a queue when
// an access is driven and is popped when the controller leaves its stall.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite;
    logic [31:0] addr, wdata;
    logic [31:0] memData;
    logic        stall, misalign, busErr, req, we;
    logic [31:0] reqAddr, reqWdata;
    logic        ack;
    logic [31:0] rdata;

    // Second instance with a short watchdog for the timeout scenario.
    logic        rdT, wrT, ackT;
    logic [31:0] addrT, wdataT, rdataT;
    logic [31:0] memDataT, reqAddrT, reqWdataT;
    logic        stallT, misalignT, busErrT, reqT, weT;

    int checks = 0;
    int miscompares = 0;
    logic [31:0] lastData = 32'd0;
    logic [31:0] sbQ[$];

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk_i(clk), .rst_i(rst), .MemRead_i(memRead), .MemWrite_i(memWrite),
        .Addr_i(addr), .WriteData_i(wdata), .MemData_o(memData), .stall_o(stall),
        .misalign_o(misalign), .bus_err_o(busErr), .mem_req_o(req), .mem_we_o(we),
        .mem_addr_o(reqAddr), .mem_wdata_o(reqWdata), .mem_ack_i(ack), .mem_rdata_i(rdata)
    );

    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dutTo (
        .clk_i(clk), .rst_i(rst), .MemRead_i(rdT), .MemWrite_i(wrT),
        .Addr_i(addrT), .WriteData_i(wdataT), .MemData_o(memDataT), .stall_o(stallT),
        .misalign_o(misalignT), .bus_err_o(busErrT), .mem_req_o(reqT), .mem_we_o(weT),
        .mem_addr_o(reqAddrT), .mem_wdata_o(reqWdataT), .mem_ack_i(ackT), .mem_rdata_i(rdataT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access at posedge+1 of an IDLE cycle; ack arrives in busy cycle k.
    // Returns at posedge+1 of the IDLE cycle following DONE.
    task automatic doAccess(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd_data, input int k);
        logic [31:0] expData;
        int stalls;
        expData  = wr ? lastData : rd_data;
        sbQ.push_back(expData);
        lastData = expData;
        memRead  = rd;
        memWrite = wr;
        addr     = a;
        wdata    = wd;
        #1;
        stalls = 0;
        chk("enter_stall", {31'd0, stall}, 32'd1);
        if (stall) stalls++;
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            ack   = (i == k);
            rdata = rd_data;
            #1;
            chk("busy_req", {31'd0, req}, 32'd1);
            chk("busy_we", {31'd0, we}, {31'd0, wr});
            chk("busy_addr", reqAddr, a & 32'hFFFF_FFFC);
            chk("busy_wdata", reqWdata, wd);
            if (stall) stalls++;
        end
        @(posedge clk); #1;
        ack   = 1'b0;
        rdata = $urandom;
        #1;
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_req", {31'd0, req}, 32'd0);
        chk("done_buserr", {31'd0, busErr}, 32'd0);
        if (sbQ.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            chk("done_memdata", memData, sbQ.pop_front());
        end
        chk("stall_cycles", stalls, k + 1);
        @(posedge clk); #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    initial begin
        int reqCycles;
        rst = 1'b1;
        memRead = 1'b0; memWrite = 1'b0; addr = 32'd0; wdata = 32'd0;
        ack = 1'b0; rdata = 32'd0;
        rdT = 1'b0; wrT = 1'b0; addrT = 32'd0; wdataT = 32'd0; ackT = 1'b0; rdataT = 32'd0;

        // Reset state and combinational gating while reset is held.
        @(posedge clk); #1;
        memRead = 1'b1; addr = 32'h3;
        #1;
        chk("rst_misalign_gate", {31'd0, misalign}, 32'd0);
        chk("rst_stall_gate", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memRead = 1'b0; addr = 32'd0;
        #1;
        chk("rst_memdata", memData, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_addr", reqAddr, 32'd0);
        chk("rst_wdata", reqWdata, 32'd0);
        chk("rst_buserr", {31'd0, busErr}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        // Load, ack in the first busy cycle.
        doAccess(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1);
        // Store, ack after five busy cycles; load data must be kept.
        doAccess(1'b0, 1'b1, 32'h100, 32'h1234_5678, 32'hCAFE_F00D, 5);
        // Read and write together behave as a store.
        doAccess(1'b1, 1'b1, 32'h204, 32'hA5A5_5A5A, 32'h0BAD_0BAD, 2);

        // Misaligned load: flagged, never requested, data untouched.
        memRead = 1'b1; addr = 32'h43;
        #1;
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_memdata", memData, lastData);
        memRead = 1'b0;
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        @(posedge clk); #1;
        chk("mis_req2", {31'd0, req}, 32'd0);

        // Back-to-back loads with no gap beyond DONE.
        doAccess(1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_000A, 1);
        doAccess(1'b1, 1'b0, 32'h14, 32'h0, 32'h0000_000B, 1);

        // Reset in the second busy cycle abandons the transaction.
        memRead = 1'b1; addr = 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_stall_gate", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; memRead = 1'b0;
        lastData = 32'd0;
        #1;
        chk("midrst_req", {31'd0, req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_memdata", memData, 32'd0);
        ack = 1'b1; rdata = 32'h5555_5555;
        @(posedge clk); #1;
        ack = 1'b0;
        #1;
        chk("stale_ack_memdata", memData, 32'd0);
        chk("stale_ack_req", {31'd0, req}, 32'd0);
        chk("stale_ack_stall", {31'd0, stall}, 32'd0);

        // Timeout on the short-watchdog instance.
        rdT = 1'b1; addrT = 32'h80;
        #1;
        chk("to_enter_stall", {31'd0, stallT}, 32'd1);
        reqCycles = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #2;
            if (!reqT) break;
            reqCycles++;
        end
        chk("to_req_cycles", reqCycles, 32'd4);
        chk("to_buserr", {31'd0, busErrT}, 32'd1);
        chk("to_memdata", memDataT, 32'd0);
        chk("to_done_stall", {31'd0, stallT}, 32'd0);
        @(posedge clk); #1;
        rdT = 1'b0;
        #1;
        chk("to_buserr_pulse", {31'd0, busErrT}, 32'd0);
        chk("to_idle_stall", {31'd0, stallT}, 32'd0);
        chk("to_idle_req", {31'd0, reqT}, 32'd0);

        chk("sb_empty", sbQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
